sram_bus_arbiter: RTL and testbench

Shares one memory bus port between the pipeline's instruction-fetch requester (IF) and data requester (MEM).
- Each side uses a req / addr_ok / data_ok split handshake.
- Exactly one transaction is outstanding at a time.
- Data requests have priority; a starvation counter bounds how long fetch can wait.
- Sits between the datapath's SRAM-style ports and the external bus bridge.

---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/sram_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the SRAM-style bus arbiter: FSM states, bus owner,
// transfer size codes and the latched request-field bundle.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-style bus port between instruction fetch and data access.
// One transaction is outstanding at a time; data has priority, and a
// starvation counter forces a waiting fetch through after STARVE_MAX data
// grants have passed it over.
//
// Handshake: a requester raises req with its fields and holds both until
// addr_ok (a same-cycle combinational accept, only given in IDLE). The
// response arrives later as a one-cycle data_ok (reads and writes alike),
// with rdata valid only in that cycle and 0 otherwise. On the bus side,
// mem_req is held with stable fields until mem_addr_ok; mem_data_ok is only
// meaningful after the address has been accepted.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output state_e      o_dbg_state
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     r_state;
    owner_e     r_owner;
    logic [3:0] r_starve_cnt;
    req_t       r_req;
    logic       r_mem_req;

    logic w_idle;
    logic w_force_inst;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_resp;
    req_t w_inst_fields;
    req_t w_data_fields;

    assign w_inst_fields = '{wr: 1'b0, size: SZ_WORD, addr: inst_addr, wstrb: 4'h0, wdata: 32'h0};
    assign w_data_fields = '{wr: data_wr, size: data_size, addr: data_addr,
                             wstrb: data_wstrb, wdata: data_wdata};

    // Grant selection: data wins unless fetch has been passed over too often.
    // Reset also blocks grants so nothing is accepted while rst_n is low.
    always_comb begin
        w_idle       = rst_n && (r_state == ST_IDLE);
        w_force_inst = inst_req && (r_starve_cnt == STARVE_LIM);
        w_grant_data = w_idle && data_req && !w_force_inst;
        w_grant_inst = w_idle && inst_req && !w_grant_data;
        w_resp       = (r_state == ST_DATA) && mem_data_ok;
    end

    // Requester-facing outputs: accept pulses and owner-steered response.
    always_comb begin
        inst_addr_ok = w_grant_inst;
        data_addr_ok = w_grant_data;
        inst_data_ok = w_resp && (r_owner == OWN_INST);
        data_data_ok = w_resp && (r_owner == OWN_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    end

    assign mem_req     = r_mem_req;
    assign mem_wr      = r_req.wr;
    assign mem_size    = r_req.size;
    assign mem_addr    = r_req.addr;
    assign mem_wstrb   = r_req.wstrb;
    assign mem_wdata   = r_req.wdata;
    assign o_dbg_state = r_state;

    // Transaction FSM: latch the grantee, drive the bus address phase, wait for the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_INST;
            r_starve_cnt <= 4'd0;
            r_req        <= '0;
            r_mem_req    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_data) begin
                        r_owner   <= OWN_DATA;
                        r_req     <= w_data_fields;
                        r_mem_req <= 1'b1;
                        r_state   <= ST_ADDR;
                        if (inst_req && (r_starve_cnt != STARVE_LIM))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end else if (w_grant_inst) begin
                        r_owner      <= OWN_INST;
                        r_req        <= w_inst_fields;
                        r_mem_req    <= 1'b1;
                        r_state      <= ST_ADDR;
                        r_starve_cnt <= 4'd0;
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mem_data_ok)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // A response before the address is accepted is a bus protocol violation; it is ignored.
    a_no_early_resp: assert property (@(posedge clk) disable iff (!rst_n)
                                      !((r_state == ST_ADDR) && mem_data_ok))
        else $warning("sram_bus_arbiter: mem_data_ok during address phase ignored");

    // Only one requester may be accepted in any cycle.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(inst_addr_ok && data_addr_ok))
        else $error("sram_bus_arbiter: both requesters accepted in one cycle");

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized bench for sram_bus_arbiter. The bench plays both
// requesters and the bus, and predicts grants and responses from the
// arbitration rules (data first, fetch forced after STARVE_MAX pass-overs).
module tb_sram_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          passed_over = 0;   // data grants taken while fetch waited, since fetch was last served
    string       grants = "";
    logic [32:0] exp_q[$];          // {owner_is_data, expected rdata}

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sram_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
    );

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
        chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
        chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'd0);
        chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'd0);
        chk({tag, "_inst_rdata"}, inst_rdata, 32'd0);
        chk({tag, "_data_rdata"}, data_rdata, 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_size"}, 32'(mem_size), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic chk_addr_phase(input req_t e);
        chk("addr_mem_req", 32'(mem_req), 32'd1);
        chk("addr_mem_wr", 32'(mem_wr), 32'(e.wr));
        chk("addr_mem_size", 32'(mem_size), 32'(e.size));
        chk("addr_mem_addr", mem_addr, e.addr);
        chk("addr_mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        chk("addr_mem_wdata", mem_wdata, e.wdata);
        chk("addr_no_grant", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("addr_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("addr_rdata_zero", inst_rdata | data_rdata, 32'd0);
    endtask

    // Called at posedge+1 with requests driven. Runs one full transaction:
    // grant, a_stall address-wait cycles, accept, d_stall response-wait
    // cycles, response. Returns at posedge+1 of the following IDLE cycle.
    task automatic run_txn(input int a_stall, input int d_stall, input bit keep_req,
                           input bit spurious, input logic [31:0] rd);
        logic        pick_data;
        req_t        e;
        logic [32:0] exp;
        #2;
        pick_data = data_req && !(inst_req && passed_over == STARVE_MAX);
        chk("grant_data", 32'(data_addr_ok), 32'(pick_data));
        chk("grant_inst", 32'(inst_addr_ok), 32'(!pick_data && inst_req));
        if (pick_data) begin
            e = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};
            if (inst_req && passed_over < 15) passed_over++;
            grants = {grants, "D"};
        end else begin
            e = '{wr: 1'b0, size: SZ_WORD, addr: inst_addr, wstrb: 4'h0, wdata: 32'h0};
            passed_over = 0;
            grants = {grants, "I"};
        end
        exp_q.push_back({pick_data, rd});
        tick();
        if (!keep_req) begin
            if (pick_data) data_req = 1'b0;
            else inst_req = 1'b0;
        end
        for (int i = 0; i < a_stall; i++) begin
            mem_addr_ok = 1'b0;
            mem_data_ok = spurious && (i == 0);
            mem_rdata   = ~rd;
            #2;
            chk_addr_phase(e);
            tick();
        end
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        #2;
        chk_addr_phase(e);
        tick();
        mem_addr_ok = 1'b0;
        for (int i = 0; i < d_stall; i++) begin
            mem_rdata = $urandom;
            #2;
            chk("wait_mem_req", 32'(mem_req), 32'd0);
            chk("wait_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
            chk("wait_rdata_zero", inst_rdata | data_rdata, 32'd0);
            chk("wait_no_grant", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            tick();
        end
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #2;
        exp = exp_q.pop_front();
        chk("resp_inst_data_ok", 32'(inst_data_ok), 32'(!exp[32]));
        chk("resp_data_data_ok", 32'(data_data_ok), 32'(exp[32]));
        chk("resp_inst_rdata", inst_rdata, exp[32] ? 32'h0 : exp[31:0]);
        chk("resp_data_rdata", data_rdata, exp[32] ? exp[31:0] : 32'h0);
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        chk("resp_no_grant", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic new_inst();
        inst_req  = 1'b1;
        inst_addr = {$urandom} & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
        data_wstrb = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        chk_all_zero("reset");

        // Fetch alone with a zero-wait bus
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        run_txn(0, 0, 1'b0, 1'b0, 32'h3C1D_0001);

        // Simultaneous requests: data write first, then the waiting fetch
        grants = "";
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b1; data_size = SZ_WORD; data_addr = 32'h8000_1004;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        run_txn(0, 0, 1'b0, 1'b0, 32'h0000_0000);
        run_txn(0, 0, 1'b0, 1'b0, 32'h1234_5678);
        n_checks++;
        assert (grants == "DI") n_pass++;
        else $error("FAIL simul_order observed=%s expected=DI", grants);

        // Both held continuously: fetch forced through every fourth grant
        grants = "";
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b0; data_size = SZ_HALF; data_addr = 32'h8000_2002;
        data_wstrb = 4'h0; data_wdata = 32'h0;
        for (int k = 0; k < 8; k++) run_txn(0, 0, 1'b1, 1'b0, $urandom);
        n_checks++;
        assert (grants == "DDDIDDDI") n_pass++;
        else $error("FAIL starve_order observed=%s expected=DDDIDDDI", grants);
        inst_req = 1'b0; data_req = 1'b0;

        // Bus stalls with a fetch waiting: no grant until after the response
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        data_req = 1'b1; data_wr = 1'b0; data_size = SZ_BYTE; data_addr = 32'h8000_3003;
        data_wstrb = 4'h8; data_wdata = 32'hA5A5_A5A5;
        run_txn(4, 5, 1'b0, 1'b0, 32'hCAFE_F00D);
        run_txn(0, 0, 1'b0, 1'b0, 32'h0BAD_BEEF);

        // Reset while a data read is waiting for its response
        data_req = 1'b1; data_wr = 1'b0; data_size = SZ_WORD; data_addr = 32'h8000_4000;
        data_wstrb = 4'h0; data_wdata = 32'h5555_AAAA;
        #2;
        chk("rst_case_grant", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0;
        mem_addr_ok = 1'b1;
        #2;
        chk("rst_case_mem_req", 32'(mem_req), 32'd1);
        tick();
        mem_addr_ok = 1'b0;
        #2;
        chk("rst_case_in_data", 32'(dbg_state), 32'(ST_DATA));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk_all_zero("midreset");
        passed_over = 0;
        exp_q.delete();
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
        run_txn(0, 0, 1'b0, 1'b0, 32'h2408_0001);

        // Spurious bus response during the address phase
        inst_req = 1'b1; inst_addr = 32'hBFC0_0400;
        run_txn(2, 1, 1'b0, 1'b1, 32'h8C01_0004);

        // Randomized traffic with random bus stalls
        passed_over = 0;
        new_inst();
        new_data();
        for (int k = 0; k < 40; k++) begin
            int a;
            a = $urandom_range(0, 3);
            run_txn(a, $urandom_range(0, 3), 1'b0, (a > 0) && ($urandom_range(0, 3) == 0), $urandom);
            if (!inst_req && $urandom_range(0, 1) == 1) new_inst();
            if (!data_req && $urandom_range(0, 3) != 0) new_data();
            if (!inst_req && !data_req) new_inst();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
